sync_stream_fifo: RTL

//   Single-clock valid/ready stream buffer, parametrised successor to the one-word CDC handshake path.

---
 rtl/sync_stream_fifo_pkg.sv | 24 ++
 rtl/sync_stream_fifo_if.sv | 34 +++
 rtl/sync_fifo_mem.sv | 34 +++
 rtl/sync_stream_fifo.sv | 83 ++++++++
 4 files changed

// File: rtl/sync_stream_fifo_pkg.sv
// Shared types and helpers for the synchronous stream FIFO.
//   fifo_flags_t : registered status flags of the buffer
//   FLAGS_IDLE   : flag values after reset or flush
//   clog2        : ceiling log2 for parameter-derived widths
package sync_stream_fifo_pkg;

  typedef struct packed {
    logic wd_ready;
    logic rd_valid;
    logic almost_full;
    logic wd_drop;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_IDLE = '{wd_ready: 1'b1, rd_valid: 1'b0,
                                         almost_full: 1'b0, wd_drop: 1'b0};

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(value)) w++;
    return w;
  endfunction

endpackage

// File: rtl/sync_stream_fifo_if.sv
// Write/read stream bundle of sync_stream_fifo.
//   slave  : FIFO side (consumes wd_*, flush_i, rd_ready_i; drives status and read data)
//   master : producer/consumer side
interface sync_stream_fifo_if
  import sync_stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) ();

  localparam int unsigned LVL_W = clog2(DEPTH + 1);

  logic                  flush_i;
  logic                  wd_valid_i;
  logic [DATA_WIDTH-1:0] wd_data_i;
  logic                  wd_ready_o;
  logic                  wd_drop_o;
  logic                  rd_ready_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  rd_valid_o;
  logic [LVL_W-1:0]      level_o;
  logic                  almost_full_o;

  modport slave (
    input  flush_i, wd_valid_i, wd_data_i, rd_ready_i,
    output wd_ready_o, wd_drop_o, rd_data_o, rd_valid_o, level_o, almost_full_o
  );

  modport master (
    output flush_i, wd_valid_i, wd_data_i, rd_ready_i,
    input  wd_ready_o, wd_drop_o, rd_data_o, rd_valid_o, level_o, almost_full_o
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one
// asynchronous read port. Storage is intentionally not reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
module sync_fifo_mem
  import sync_stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_W     = clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Async read port
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_stream_fifo.sv
// Single-clock valid/ready stream buffer holding up to DEPTH words with
// first-word-fall-through read, fill level, almost-full, flush and a
// one-cycle dropped-write pulse.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   s     : stream bundle (slave modport of sync_stream_fifo_if)
module sync_stream_fifo
  import sync_stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned DEPTH             = 4,
  parameter int unsigned ALMOST_FULL_LEVEL = DEPTH - 1
) (
  input logic               clk_i,
  input logic               rst_i,
  sync_stream_fifo_if.slave s
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned LVL_W = clog2(DEPTH + 1);

  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [LVL_W-1:0]      level_q;
  logic [LVL_W-1:0]      level_nxt;
  fifo_flags_t           flags_q;
  fifo_flags_t           flags_nxt;
  logic                  push;
  logic                  pop;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] rd_data;

  // Handshakes and next level/flags; flags depend only on registered state
  // and this cycle's inputs, so wd_ready_o never sees rd_ready_i combinationally.
  always_comb begin
    push      = s.wd_valid_i & flags_q.wd_ready;
    pop       = flags_q.rd_valid & s.rd_ready_i;
    level_nxt = level_q;
    if (push && !pop)      level_nxt = level_q + LVL_W'(1);
    else if (pop && !push) level_nxt = level_q - LVL_W'(1);
    flags_nxt             = FLAGS_IDLE;
    flags_nxt.wd_ready    = (level_nxt != LVL_W'(DEPTH));
    flags_nxt.rd_valid    = (level_nxt != '0);
    flags_nxt.almost_full = (level_nxt >= LVL_W'(ALMOST_FULL_LEVEL));
    flags_nxt.wd_drop     = s.wd_valid_i & ~flags_q.wd_ready;
    mem_we                = push & ~s.flush_i & ~rst_i;
  end

  // Pointers, level and flags; reset and flush share the same empty state
  always_ff @(posedge clk_i) begin
    if (rst_i || s.flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      flags_q  <= FLAGS_IDLE;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_nxt;
      flags_q <= flags_nxt;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (s.wd_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign s.wd_ready_o    = flags_q.wd_ready;
  assign s.rd_valid_o    = flags_q.rd_valid;
  assign s.almost_full_o = flags_q.almost_full;
  assign s.wd_drop_o     = flags_q.wd_drop;
  assign s.level_o       = level_q;
  assign s.rd_data_o     = rd_data;

endmodule
